// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl_if: byte-stream, register-file, ALU and TX FIFO signals of the command controller.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_valid;
  logic [ADDR_WIDTH-1:0]    rf_addr;
  logic                     rf_wr_en;
  logic [DATA_WIDTH-1:0]    rf_wr_data;
  logic                     rf_rd_en;
  logic [DATA_WIDTH-1:0]    rf_rd_data;
  logic                     rf_rd_valid;
  logic                     alu_en;
  logic [ALU_FUN_WIDTH-1:0] alu_fun;
  logic [2*DATA_WIDTH-1:0]  alu_out;
  logic                     alu_out_valid;
  logic                     clk_gate_en;
  logic [DATA_WIDTH-1:0]    tx_data;
  logic                     tx_wr_en;
  logic                     tx_full;
  logic                     cmd_error;
  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, clk_gate_en, tx_data, tx_wr_en, cmd_error
  );
  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, clk_gate_en, tx_data, tx_wr_en, cmd_error
  );
endinterface

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: framed command decoder driving register file, ALU and TX FIFO.
// Define CMD_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES cycles.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic            clk,
  input logic            rst_n,
  sys_cmd_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD
  } state_t;
  localparam logic [DATA_WIDTH-1:0] OP_WR = 'hAA, OP_RD = 'hBB, OP_ALU = 'hCC, OP_FUN = 'hDD;
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [DATA_WIDTH-1:0] data, data_d;
  logic [ALU_FUN_WIDTH-1:0] fun, fun_d;
  logic [2*DATA_WIDTH-1:0] res, res_d;
  logic wr, wr_d, rd, rd_d, alu, alu_d, err, err_d, gate, gate_d;
  logic in_tx, busy, timeout;
  assign in_tx = state inside {TX_LO, TX_HI, TX_RD};
  assign busy  = in_tx || state inside {RD_WAIT, ALU_WAIT};
`ifdef CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic kick;
  assign kick    = bus.rx_valid || bus.rf_rd_valid || bus.alu_out_valid;
  assign timeout = state != IDLE && !kick && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == IDLE || kick || timeout) ? '0 : cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      data  <= '0;
      fun   <= '0;
      res   <= '0;
      {wr, rd, alu, err, gate} <= '0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      data  <= data_d;
      fun   <= fun_d;
      res   <= res_d;
      {wr, rd, alu, err, gate} <= {wr_d, rd_d, alu_d, err_d, gate_d};
    end
  always_comb begin
    state_d = state;
    addr_d  = addr;
    data_d  = data;
    fun_d   = fun;
    res_d   = res;
    gate_d  = gate;
    {wr_d, rd_d, alu_d, err_d} = '0;
    case (state)
      IDLE: if (bus.rx_valid) begin
        state_d = bus.rx_data == OP_WR  ? WR_ADDR :
                  bus.rx_data == OP_RD  ? RD_ADDR :
                  bus.rx_data == OP_ALU ? OP_A    :
                  bus.rx_data == OP_FUN ? ALU_FUN : IDLE;
        err_d   = state_d == IDLE;
        gate_d  = state_d == ALU_FUN;
      end
      WR_ADDR: if (bus.rx_valid) begin
        addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (bus.rx_valid) begin
        data_d  = bus.rx_data;
        wr_d    = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: if (bus.rx_valid) begin
        addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
        rd_d    = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (bus.rf_rd_valid) begin
        res_d   = {{DATA_WIDTH{1'b0}}, bus.rf_rd_data};
        state_d = TX_RD;
      end
      OP_A: if (bus.rx_valid) begin
        data_d  = bus.rx_data;
        addr_d  = '0;
        wr_d    = 1'b1;
        state_d = OP_B;
      end
      OP_B: if (bus.rx_valid) begin
        data_d  = bus.rx_data;
        addr_d  = ADDR_WIDTH'(1);
        wr_d    = 1'b1;
        gate_d  = 1'b1;
        state_d = ALU_FUN;
      end
      ALU_FUN: if (bus.rx_valid) begin
        fun_d   = bus.rx_data[ALU_FUN_WIDTH-1:0];
        alu_d   = 1'b1;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: if (bus.alu_out_valid) begin
        res_d   = bus.alu_out;
        state_d = TX_LO;
      end
      TX_LO: state_d = bus.tx_full ? TX_LO : TX_HI;
      TX_HI: if (!bus.tx_full) begin
        gate_d  = 1'b0;
        state_d = IDLE;
      end
      TX_RD: state_d = bus.tx_full ? TX_RD : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.rx_valid && busy) err_d = 1'b1;
    if (timeout) begin
      state_d = IDLE;
      {wr_d, rd_d, alu_d, gate_d} = '0;
      err_d   = 1'b1;
    end
  end
  assign bus.rf_addr     = addr;
  assign bus.rf_wr_data  = data;
  assign bus.rf_wr_en    = wr;
  assign bus.rf_rd_en    = rd;
  assign bus.alu_en      = alu;
  assign bus.alu_fun     = fun;
  assign bus.clk_gate_en = gate;
  assign bus.cmd_error   = err;
  assign bus.tx_wr_en    = in_tx && !bus.tx_full && !timeout;
  assign bus.tx_data     = state == TX_HI ? res[2*DATA_WIDTH-1:DATA_WIDTH] :
                           in_tx          ? res[DATA_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: directed frames against sys_cmd_ctrl with hand-computed expectations.
module tb_sys_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sys_cmd_ctrl_if bus ();
  sys_cmd_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int passed = 0;
  logic [11:0] wr_q[$];
  logic [7:0] tx_q[$];
  int rd_cnt = 0, alu_cnt = 0, err_cnt = 0;
  always @(posedge clk) begin
    if (bus.rf_wr_en) wr_q.push_back({bus.rf_addr, bus.rf_wr_data});
    if (bus.rf_rd_en) rd_cnt++;
    if (bus.alu_en) alu_cnt++;
    if (bus.tx_wr_en) tx_q.push_back(bus.tx_data);
    if (bus.cmd_error) err_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic clear();
    wr_q.delete();
    tx_q.delete();
    rd_cnt = 0;
    alu_cnt = 0;
    err_cnt = 0;
  endtask
  task automatic wait_alu();
    for (int n = 0; n < 20 && !bus.alu_en; n++) @(negedge clk);
    check("alu_en_seen", bus.alu_en, 1);
  endtask
  initial begin
    bus.rx_data = '0; bus.rx_valid = 0; bus.rf_rd_data = '0; bus.rf_rd_valid = 0;
    bus.alu_out = '0; bus.alu_out_valid = 0; bus.tx_full = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {bus.rf_wr_en, bus.rf_rd_en, bus.alu_en, bus.tx_wr_en, bus.cmd_error, bus.clk_gate_en}, 0);
    check("rst_bus", {bus.rf_addr, bus.rf_wr_data, bus.alu_fun, bus.tx_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clear();
    // RF write
    send(8'hAA); send(8'h05); send(8'h3C);
    repeat (3) @(negedge clk);
    check("wr_count", wr_q.size(), 1);
    check("wr_addr_data", wr_q[0], 12'h53C);
    check("wr_no_tx", tx_q.size(), 0);
    check("wr_no_err", err_cnt, 0);
    clear();
    // RF read with 3-cycle read latency
    send(8'hBB); send(8'h05);
    for (int n = 0; n < 20 && !bus.rf_rd_en; n++) @(negedge clk);
    check("rd_en_seen", bus.rf_rd_en, 1);
    check("rd_addr", bus.rf_addr, 5);
    repeat (3) @(negedge clk);
    bus.rf_rd_data = 8'h3C; bus.rf_rd_valid = 1'b1;
    @(negedge clk);
    bus.rf_rd_valid = 1'b0; bus.rf_rd_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rd_count", rd_cnt, 1);
    check("rd_tx_count", tx_q.size(), 1);
    check("rd_tx_byte", tx_q[0], 8'h3C);
    clear();
    // ALU with operands, stray byte during ALU_WAIT
    send(8'hCC); send(8'h07); send(8'h03);
    check("cc_gate_on", bus.clk_gate_en, 1);
    send(8'h00);
    wait_alu();
    check("cc_fun", bus.alu_fun, 0);
    send(8'h77);
    @(negedge clk);
    check("cc_stray_err", err_cnt, 1);
    bus.alu_out = 16'h000A; bus.alu_out_valid = 1'b1;
    @(negedge clk);
    bus.alu_out_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("cc_wr_count", wr_q.size(), 2);
    check("cc_wr0", wr_q[0], 12'h007);
    check("cc_wr1", wr_q[1], 12'h103);
    check("cc_alu_count", alu_cnt, 1);
    check("cc_tx_count", tx_q.size(), 2);
    check("cc_tx_lo", tx_q[0], 8'h0A);
    check("cc_tx_hi", tx_q[1], 8'h00);
    check("cc_gate_off", bus.clk_gate_en, 0);
    check("cc_err_total", err_cnt, 1);
    clear();
    // ALU without operands, FIFO full backpressure, byte together with result
    bus.tx_full = 1'b1;
    send(8'hDD);
    check("dd_gate_on", bus.clk_gate_en, 1);
    send(8'h02);
    wait_alu();
    check("dd_fun", bus.alu_fun, 2);
    bus.alu_out = 16'h1234; bus.alu_out_valid = 1'b1;
    bus.rx_data = 8'h99; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.alu_out_valid = 1'b0; bus.rx_valid = 1'b0; bus.alu_out = '0;
    for (int n = 0; n < 10; n++) begin
      check("dd_hold", {bus.tx_wr_en, bus.tx_data}, 9'h034);
      @(negedge clk);
    end
    check("dd_gate_hold", bus.clk_gate_en, 1);
    bus.tx_full = 1'b0;
    repeat (4) @(negedge clk);
    check("dd_tx_count", tx_q.size(), 2);
    check("dd_tx_lo", tx_q[0], 8'h34);
    check("dd_tx_hi", tx_q[1], 8'h12);
    check("dd_err", err_cnt, 1);
    check("dd_gate_off", bus.clk_gate_en, 0);
    check("dd_no_wr", wr_q.size(), 0);
    clear();
    // Unknown opcode, then a normal frame still works
    send(8'h55);
    @(negedge clk);
    check("bad_err", err_cnt, 1);
    send(8'hAA); send(8'h1F); send(8'hE1);
    repeat (2) @(negedge clk);
    check("bad_then_wr", wr_q.size(), 1);
    check("bad_then_wr_val", wr_q[0], 12'hFE1);
    check("bad_err_total", err_cnt, 1);
    clear();
    // Reset mid-frame discards the partial command
    send(8'hAA); send(8'h05);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", {bus.rf_wr_en, bus.cmd_error, bus.clk_gate_en, bus.rf_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C);
    repeat (2) @(negedge clk);
    check("midrst_no_wr", wr_q.size(), 0);
    check("midrst_err", err_cnt, 1);
    clear();
`ifdef CMD_TIMEOUT_EN
    send(8'hAA); send(8'h05);
    repeat (1030) @(negedge clk);
    check("to_err", err_cnt, 1);
    check("to_no_wr", wr_q.size(), 0);
    send(8'hAA); send(8'h06); send(8'h11);
    repeat (2) @(negedge clk);
    check("to_next_wr", wr_q.size(), 1);
    check("to_next_val", wr_q[0], 12'h611);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
